// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a ROWS x COLS switch matrix. One row line is driven at a time
// (one-hot, registered). The column sense lines are sampled on each scan
// tick (en), and a closed key is debounced before it is accepted. An
// accepted press puts an event into a single-entry event slot that a
// consumer drains with a valid/ready handshake.
//
// Key codes are row_index*COLS + col_index. When several columns are
// closed on the driven row, the lowest column index wins. The null code
// (no key) is all ones.
//
// Optional feature: define KEYPAD_SCANNER_RELEASE_EN to also emit release
// events. ev_code then gains an extra MSB: 0 = press, 1 = release.
//
// Ports
//   clk       in   sole clock
//   rst       in   synchronous active-high reset
//   en        in   scan tick; FSM, counters and row drive advance only when 1
//   keypadc   in   [COLS] column sense, 1 = key closed on the driven row
//   keypadr   out  [ROWS] one-hot row drive
//   key       out  [KW] debounced held-key code, null when no key is held
//   ev_valid  out  event pending in the slot
//   ev_code   out  [EW] code of the pending event
//   ev_ready  in   consumer takes the event when ev_valid=1 at a clk edge
//   overflow  out  sticky: an event was dropped because the slot was full
// ----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int  ROWS     = 4,
    parameter int  COLS     = 3,
    parameter int  DEBOUNCE = 3,
    localparam int KW       = $clog2(ROWS * COLS + 1),
`ifdef KEYPAD_SCANNER_RELEASE_EN
    localparam int EW       = KW + 1
`else
    localparam int EW       = KW
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [COLS-1:0] keypadc,
    output logic [ROWS-1:0] keypadr,
    output logic [KW-1:0]   key,
    output logic            ev_valid,
    output logic [EW-1:0]   ev_code,
    input  logic            ev_ready,
    output logic            overflow
);

    localparam logic [KW-1:0] NULL_CODE = '1;
    localparam logic [3:0]    DB_LAST   = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      count_reg, count_next;
    logic [ROWS-1:0] keypadr_reg, keypadr_next;
    logic [KW-1:0]   code_reg, code_next;
    logic [KW-1:0]   key_reg, key_next;
    logic            ev_valid_reg;
    logic [EW-1:0]   ev_code_reg;
    logic            overflow_reg;

    logic            emit;
    logic [EW-1:0]   emit_code;

    // ------------------------------------------------------------------
    // Row rotation: one position toward the MSB, MSB wraps to bit 0.
    // ------------------------------------------------------------------
    logic [ROWS-1:0] row_rot;
    assign row_rot[0] = keypadr_reg[ROWS-1];

    genvar gi;
    generate
        for (gi = 1; gi < ROWS; gi++) begin : g_rot
            assign row_rot[gi] = keypadr_reg[gi-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Code of the key currently sensed on the driven row.
    // ------------------------------------------------------------------
    int            row_idx;
    int            col_idx;
    logic          col_hit;
    logic [KW-1:0] sample_code;
    logic [EW-1:0] press_code;

    always_comb begin
        row_idx = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (keypadr_reg[r]) begin
                row_idx = r;
            end
        end
    end

    // Scan from the top down so the lowest closed column overwrites last.
    always_comb begin
        col_idx = 0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (keypadc[c]) begin
                col_idx = c;
            end
        end
    end

    assign col_hit     = |keypadc;
    assign sample_code = KW'(row_idx * COLS + col_idx);

`ifdef KEYPAD_SCANNER_RELEASE_EN
    assign press_code = {1'b0, sample_code};
`else
    assign press_code = sample_code;
`endif

    // ------------------------------------------------------------------
    // Next-state logic. A press event is only ever emitted when the
    // sampled code matches the candidate, so sample_code is the press
    // code in every emitting branch.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        keypadr_next = keypadr_reg;
        code_next    = code_reg;
        key_next     = key_reg;
        emit         = 1'b0;
        emit_code    = press_code;

        if (en) begin
            case (state_reg)
                ST_SCAN: begin
                    if (col_hit) begin
                        code_next  = sample_code;
                        count_next = 4'd1;
                        if (DEBOUNCE == 1) begin
                            state_next = ST_HELD;
                            key_next   = sample_code;
                            emit       = 1'b1;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end else begin
                        keypadr_next = row_rot;
                    end
                end

                ST_DEBOUNCE: begin
                    if (col_hit && (sample_code == code_reg)) begin
                        count_next = count_reg + 4'd1;
                        if (count_next == DB_LAST) begin
                            state_next = ST_HELD;
                            key_next   = sample_code;
                            emit       = 1'b1;
                        end
                    end else begin
                        // Bounce or a different key: abandon and move on.
                        state_next   = ST_SCAN;
                        count_next   = 4'd0;
                        keypadr_next = row_rot;
                    end
                end

                ST_HELD: begin
                    if (!col_hit) begin
                        if (DEBOUNCE == 1) begin
                            state_next   = ST_SCAN;
                            count_next   = 4'd0;
                            key_next     = NULL_CODE;
                            keypadr_next = row_rot;
`ifdef KEYPAD_SCANNER_RELEASE_EN
                            emit         = 1'b1;
                            emit_code    = {1'b1, code_reg};
`endif
                        end else begin
                            state_next = ST_RELEASE;
                            count_next = 4'd1;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (!col_hit) begin
                        count_next = count_reg + 4'd1;
                        if (count_next == DB_LAST) begin
                            state_next   = ST_SCAN;
                            count_next   = 4'd0;
                            key_next     = NULL_CODE;
                            keypadr_next = row_rot;
`ifdef KEYPAD_SCANNER_RELEASE_EN
                            emit         = 1'b1;
                            emit_code    = {1'b1, code_reg};
`endif
                        end
                    end else begin
                        // Key bounced back closed: still the same press.
                        state_next = ST_HELD;
                        count_next = 4'd0;
                    end
                end

                default: begin
                    state_next   = ST_SCAN;
                    count_next   = 4'd0;
                    keypadr_next = {{(ROWS-1){1'b0}}, 1'b1};
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers and the single-entry event slot. The handshake runs
    // on every clk edge, independent of en.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_SCAN;
            count_reg    <= 4'd0;
            keypadr_reg  <= {{(ROWS-1){1'b0}}, 1'b1};
            code_reg     <= NULL_CODE;
            key_reg      <= NULL_CODE;
            ev_valid_reg <= 1'b0;
            ev_code_reg  <= '1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            keypadr_reg <= keypadr_next;
            code_reg    <= code_next;
            key_reg     <= key_next;

            if (emit) begin
                // Slot is free if empty or being drained on this same edge.
                if (!ev_valid_reg || ev_ready) begin
                    ev_valid_reg <= 1'b1;
                    ev_code_reg  <= emit_code;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (ev_valid_reg && ev_ready) begin
                ev_valid_reg <= 1'b0;
            end
        end
    end

    assign keypadr  = keypadr_reg;
    assign key      = key_reg;
    assign ev_valid = ev_valid_reg;
    assign ev_code  = ev_code_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner with default parameters. A virtual
// keypad (a 12-bit mask of pressed key codes) feeds the column lines from
// the row the reference model expects to be driven. The reference model
// works on integers: row index, debounce phase, candidate, streak length,
// held key and the event slot contents.
// ----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 3;
    localparam int DEB   = 3;
    localparam int KW    = 4;
    localparam int NULLC = 15;
`ifdef KEYPAD_SCANNER_RELEASE_EN
    localparam int EW    = KW + 1;
`else
    localparam int EW    = KW;
`endif

    logic            clk;
    logic            rst;
    logic            en;
    logic [COLS-1:0] keypadc;
    logic [ROWS-1:0] keypadr;
    logic [KW-1:0]   key;
    logic            ev_valid;
    logic [EW-1:0]   ev_code;
    logic            ev_ready;
    logic            overflow;

    keypad_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .DEBOUNCE (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .keypadc  (keypadc),
        .keypadr  (keypadr),
        .key      (key),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_ready (ev_ready),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model. m_phase: 0 scanning, 1 confirming press,
    // 2 key held, 3 confirming release.
    int m_row    = 0;
    int m_phase  = 0;
    int m_cand   = 0;
    int m_streak = 0;
    int m_key    = NULLC;
    int m_evcode = (1 << EW) - 1;
    bit m_evp    = 1'b0;
    bit m_ovf    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input logic [COLS-1:0] kc, input bit rdy);
        bit hit;
        int code;
        bit emit;
        int ecode;
        hit   = 1'b0;
        code  = 0;
        emit  = 1'b0;
        ecode = 0;
        if (r) begin
            m_row    = 0;
            m_phase  = 0;
            m_cand   = 0;
            m_streak = 0;
            m_key    = NULLC;
            m_evcode = (1 << EW) - 1;
            m_evp    = 1'b0;
            m_ovf    = 1'b0;
            return;
        end
        for (int c = COLS - 1; c >= 0; c--) begin
            if (kc[c]) begin
                hit  = 1'b1;
                code = m_row * COLS + c;
            end
        end
        if (e) begin
            if (m_phase == 0) begin
                if (hit) begin
                    m_cand   = code;
                    m_streak = 1;
                    m_phase  = 1;
                end else begin
                    m_row = (m_row + 1) % ROWS;
                end
            end else if (m_phase == 1) begin
                if (hit && code == m_cand) begin
                    m_streak++;
                    if (m_streak == DEB) begin
                        m_phase = 2;
                        m_key   = m_cand;
                        emit    = 1'b1;
                        ecode   = m_cand;
                    end
                end else begin
                    m_phase  = 0;
                    m_streak = 0;
                    m_row    = (m_row + 1) % ROWS;
                end
            end else if (m_phase == 2) begin
                if (!hit) begin
                    m_phase  = 3;
                    m_streak = 1;
                end
            end else begin
                if (!hit) begin
                    m_streak++;
                    if (m_streak == DEB) begin
`ifdef KEYPAD_SCANNER_RELEASE_EN
                        emit  = 1'b1;
                        ecode = (1 << KW) + m_key;
`endif
                        m_phase  = 0;
                        m_streak = 0;
                        m_key    = NULLC;
                        m_row    = (m_row + 1) % ROWS;
                    end
                end else begin
                    m_phase  = 2;
                    m_streak = 0;
                end
            end
        end
        if (emit) begin
            if (!m_evp || rdy) begin
                m_evp    = 1'b1;
                m_evcode = ecode;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_evp && rdy) begin
            m_evp = 1'b0;
        end
    endtask

    // One clk edge: drive inputs, advance the model, check all outputs.
    task automatic step(input bit r, input bit e, input logic [11:0] mask, input bit rdy);
        logic [COLS-1:0] kc;
        for (int c = 0; c < COLS; c++) begin
            kc[c] = mask[m_row * COLS + c];
        end
        rst      = r;
        en       = e;
        keypadc  = kc;
        ev_ready = rdy;
        @(posedge clk);
        model_edge(r, e, kc, rdy);
        #1;
        chk("keypadr", 32'(keypadr), 32'(1 << m_row));
        chk("key", 32'(key), 32'(m_key));
        chk("ev_valid", 32'(ev_valid), 32'(m_evp));
        chk("ev_code", 32'(ev_code), 32'(m_evcode));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Step with en=1 until the DUT reports the target held-key code.
    task automatic run_until_key(input string tag, input int target,
                                 input logic [11:0] mask, input bit rdy);
        int n;
        n = 0;
        while (key !== KW'(target) && n < 40) begin
            step(1'b0, 1'b1, mask, rdy);
            n++;
        end
        chk(tag, 32'(key), 32'(target));
    endtask

    logic [ROWS-1:0] exp_rows [4];

    initial begin
        logic [11:0] mask;
        int          dur;
        rst      = 1'b1;
        en       = 1'b0;
        keypadc  = '0;
        ev_ready = 1'b0;
        exp_rows = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        step(1'b1, 1'b0, 12'h000, 1'b0);
        step(1'b1, 1'b1, 12'h000, 1'b0);
        chk("rst_keypadr", 32'(keypadr), 32'h1);
        chk("rst_key", 32'(key), NULLC);
        chk("rst_ev_valid", 32'(ev_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // Idle scan walks the one-hot row drive
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 12'h000, 1'b0);
            chk("scan_seq", 32'(keypadr), 32'(exp_rows[i]));
        end

        // en=0 freezes the row drive
        step(1'b0, 1'b0, 12'h000, 1'b0);
        chk("en_freeze", 32'(keypadr), 32'h1);

        // Code 7 (row 2, col 1) pressed and debounced
        run_until_key("press7_wait", 7, 12'h080, 1'b0);
        chk("press7_valid", 32'(ev_valid), 1);
        chk("press7_code", 32'(ev_code), 7);
        chk("press7_row", 32'(keypadr), 32'h4);
        step(1'b0, 1'b1, 12'h080, 1'b0);
        chk("held_frozen", 32'(keypadr), 32'h4);
        step(1'b0, 1'b1, 12'h000, 1'b1);
        chk("ready_clears", 32'(ev_valid), 0);
        run_until_key("release7_wait", NULLC, 12'h000, 1'b1);
        chk("release7_row", 32'(keypadr), 32'h8);

        // Short press (2 ticks) is rejected and scanning resumes
        while (m_row != 2) step(1'b0, 1'b1, 12'h000, 1'b0);
        step(1'b0, 1'b1, 12'h080, 1'b0);
        step(1'b0, 1'b1, 12'h080, 1'b0);
        step(1'b0, 1'b1, 12'h000, 1'b0);
        chk("bounce_row", 32'(keypadr), 32'h8);
        chk("bounce_no_ev", 32'(ev_valid), 0);

        // Overflow: slot holds code 0 while code 11 is dropped
        run_until_key("press0_wait", 0, 12'h001, 1'b0);
        run_until_key("release0_wait", NULLC, 12'h000, 1'b0);
        run_until_key("press11_wait", 11, 12'h800, 1'b0);
        chk("ovf_code_kept", 32'(ev_code), 0);
        chk("ovf_flag", 32'(overflow), 1);
        step(1'b0, 1'b1, 12'h800, 1'b1);
        chk("ovf_drain", 32'(ev_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        run_until_key("release11_wait", NULLC, 12'h000, 1'b1);

        // Reset while holding code 5 discards the pending event
        run_until_key("press5_wait", 5, 12'h020, 1'b0);
        step(1'b1, 1'b0, 12'h020, 1'b0);
        chk("rst_held_row", 32'(keypadr), 32'h1);
        chk("rst_held_key", 32'(key), NULLC);
        chk("rst_held_valid", 32'(ev_valid), 0);
        chk("rst_held_ovf", 32'(overflow), 0);

`ifdef KEYPAD_SCANNER_RELEASE_EN
        run_until_key("press4_wait", 4, 12'h010, 1'b1);
        chk("rel_press_code", 32'(ev_code), 32'h04);
        run_until_key("release4_wait", NULLC, 12'h000, 1'b1);
        chk("rel_release_valid", 32'(ev_valid), 1);
        chk("rel_release_code", 32'(ev_code), 32'h14);
`endif

        // Randomized keypad activity against the model
        for (int seg = 0; seg < 80; seg++) begin
            case ($urandom_range(0, 3))
                0:       mask = 12'h000;
                1, 2:    mask = 12'h001 << $urandom_range(0, 11);
                default: mask = 12'($urandom);
            endcase
            dur = int'($urandom_range(1, 10));
            for (int i = 0; i < dur; i++) begin
                step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0,
                     mask, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of driven row lines (2..8).
REQ-002 SHALL have parameter COLS, default 3, number of sensed column lines (1..8).
REQ-003 SHALL have parameter DEBOUNCE, default 3, consecutive identical en-tick samples required to accept a press or release (1..15).
REQ-004 SHALL have derived localparam KW = $clog2(ROWS*COLS+1), key code width; null code = all ones.
REQ-005 SHALL have port clk  input  1  sole clock; suggestion below 50 Hz scan rate via en.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port en  input  1  scan tick; all state advances only on clk edges with en=1.
REQ-008 SHALL have port keypadc  input  COLS  column sense, 1 = key closed on driven row.
REQ-009 SHALL have port keypadr  output  ROWS  one-hot row drive, registered.
REQ-010 SHALL have port key  output  KW  live debounced held-key code, null when none held.
REQ-011 SHALL have port ev_valid  output  1  event pending.
REQ-012 SHALL have port ev_code  output  KW  code of pending event.
REQ-013 SHALL have port ev_ready  input  1  consumer accepts event when ev_valid=1 at clk edge.
REQ-014 SHALL have port overflow  output  1  sticky: event lost because slot was full.

Function
REQ-015 SHALL compute code = row_index*COLS + col_index, lowest set column index winning when several are set.
REQ-016 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-017 SCAN, en tick: keypadc nonzero -> latch code, count=1, go DEBOUNCE (DEBOUNCE=1: go HELD directly, emitting event); else rotate keypadr one position toward MSB, wrapping MSB to bit 0.
REQ-018 DEBOUNCE, en tick: same code -> count+1, on count==DEBOUNCE go HELD and emit press event; different or zero -> go SCAN and rotate row.
REQ-019 HELD: keypadr frozen; key = latched code; en tick with keypadc==0 -> count=1, go RELEASE.
REQ-020 RELEASE, en tick: keypadc==0 -> count+1, on count==DEBOUNCE key=null, go SCAN and rotate row; nonzero -> back to HELD, count cleared, no new event.
REQ-021 Event slot SHALL be single entry: emission loads ev_code and sets ev_valid on the same clk edge as the state transition.
REQ-022 ev_valid && ev_ready SHALL clear ev_valid next edge; ev_code stable while ev_valid=1.
REQ-023 Emission while ev_valid=1 and ev_ready=0 SHALL drop the new event, keep old one, set overflow.
REQ-024 Emission on the same edge as acceptance SHALL load the new event with ev_valid remaining 1; overflow unchanged.
REQ-025 en=0 SHALL freeze FSM, counters and keypadr; handshake (ev_ready) still operates.
REQ-026 keypadr SHALL never be zero or multi-hot after the first clk edge with rst=1.

Reset
REQ-027 rst=1 at clk edge SHALL force state SCAN, keypadr = 1 (bit 0), key = null, ev_valid=0, ev_code=null, overflow=0, count=0, regardless of en or state.
REQ-028 Reset mid-HELD or mid-DEBOUNCE SHALL emit no event; pending event SHALL be discarded.
REQ-029 overflow SHALL clear only by rst.

Configuration
REQ-030 Macro KEYPAD_SCANNER_RELEASE_EN defined: ev_code widens to KW+1, MSB = 1 for release event emitted at RELEASE->SCAN, 0 for press; release events obey REQ-021..024.
REQ-031 Macro undefined: ev_code is KW bits, press events only; RELEASE->SCAN emits nothing.

Verification
REQ-032 Defaults, rst then en every clk, keypadc=0 -> keypadr sequence 0001,0010,0100,1000,0001 on successive edges.
REQ-033 Hold keypadc=3'b010 only while keypadr=0100 (code 7) -> ev_valid after 3 en ticks on that row, ev_code=7, key=7, keypadr frozen at 0100.
REQ-034 Press code 7 for 2 ticks then release -> no event, scan resumes at 1000.
REQ-035 ev_ready=0, press code 0 then code 11 -> ev_code stays 0, overflow=1; ev_ready=1 -> ev_valid drops next edge.
REQ-036 Assert rst during HELD with key=5 -> next edge keypadr=0001, key=null(15), ev_valid=0.
REQ-037 RELEASE_EN, press/release code 4 with ev_ready=1 -> events 5'b00100 then 5'b10100.
